// File: rtl/sr_bank_pkg.sv
// -----------------------------------------------------------------------------
// sr_bank_pkg
// Shared types and helpers for the SR-cell bank arbiter.
//   state_t    : arbiter FSM states (IDLE, DRIVE, DONE)
//   OP_SET     : per-requester op value that drives the cell's S line
//   OP_CLR     : per-requester op value that drives the cell's R line
//   cnt_width  : width of the pulse down-counter for a given pulse length
// -----------------------------------------------------------------------------
package sr_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // The counter is loaded with PULSE_CYC-1 and counts down to zero,
    // so it only needs to represent values up to PULSE_CYC-1.
    function automatic int cnt_width(input int pulse_cyc);
        return (pulse_cyc > 2) ? $clog2(pulse_cyc) : 1;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// -----------------------------------------------------------------------------
// sr_cell
// One edge-triggered SR storage cell. On a rising clk edge s=1 sets the cell
// and r=1 clears it; otherwise it holds. The arbiter never drives s and r
// together, but s wins if that ever happened so the cell stays deterministic.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset (q=0, qb=1)
//   s, r   : set / clear request for this cell
//   q, qb  : registered cell state and its complement
// -----------------------------------------------------------------------------
module sr_cell (
    input  logic clk,
    input  logic resetn,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qb
);

    logic q_r;
    logic qb_r;

    // Cell state and complement, kept as two flops so qb is also registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_r  <= 1'b0;
            qb_r <= 1'b1;
        end else if (s) begin
            q_r  <= 1'b1;
            qb_r <= 1'b0;
        end else if (r) begin
            q_r  <= 1'b0;
            qb_r <= 1'b1;
        end else begin
            q_r  <= q_r;
            qb_r <= qb_r;
        end
    end

    assign q  = q_r;
    assign qb = qb_r;

endmodule

// File: rtl/sr_bank_arbiter.sv
// -----------------------------------------------------------------------------
// sr_bank_arbiter
// Shares a bank of WIDTH SR cells between NREQ requesters. Requests are
// granted round-robin, one at a time; the winner's cell gets its S or R line
// driven for PULSE_CYC cycles, then a one-cycle done pulse is issued.
// Ports:
//   clk, resetn : clock and asynchronous active-low reset
//   req[NREQ]   : level request per requester, held until gnt
//   op[NREQ]    : 1 = set, 0 = clear
//   idx         : packed cell indices, requester i at [i*IDXW +: IDXW]
//   gnt, done   : one-hot single-cycle grant / completion pulses
//   err         : pulses with done when the granted index is out of range
//   busy        : high whenever the FSM is not in IDLE
//   s_bus,r_bus : per-cell set / clear lines, at most one bit high overall
//   q, qb       : cell states and complements
// -----------------------------------------------------------------------------
module sr_bank_arbiter
    import sr_bank_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2,
    parameter int IDXW      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        op,
    input  logic [NREQ*IDXW-1:0]   idx,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    output logic                   busy,
    output logic [WIDTH-1:0]       s_bus,
    output logic [WIDTH-1:0]       r_bus,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qb
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = cnt_width(PULSE_CYC);

    state_t            state_r;
    logic [PTRW-1:0]   rr_ptr_r;
    logic [PTRW-1:0]   win_r;
    logic [IDXW-1:0]   idx_r;
    logic [CNTW-1:0]   cnt_r;
    logic [NREQ-1:0]   gnt_r;
    logic [NREQ-1:0]   done_r;
    logic              err_r;
    logic              busy_r;
    logic [WIDTH-1:0]  s_bus_r;
    logic [WIDTH-1:0]  r_bus_r;

    logic              found_s;
    logic [PTRW-1:0]   win_s;
    logic [PTRW-1:0]   next_ptr_s;
    logic [IDXW-1:0]   win_idx_s;
    logic              win_op_s;
    int                cand_s;

    // One-hot cell mask; an index >= WIDTH yields all zeros, so an
    // out-of-range command can never touch a cell.
    function automatic logic [WIDTH-1:0] cell_mask(input logic [IDXW-1:0] i);
        logic [WIDTH-1:0] m;
        for (int k = 0; k < WIDTH; k++) begin
            m[k] = (int'(i) == k);
        end
        return m;
    endfunction

    // One-hot requester mask for gnt/done.
    function automatic logic [NREQ-1:0] req_mask(input logic [PTRW-1:0] w);
        logic [NREQ-1:0] m;
        for (int k = 0; k < NREQ; k++) begin
            m[k] = (int'(w) == k);
        end
        return m;
    endfunction

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        cand_s  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = int'(rr_ptr_r) + k;
            if (cand_s >= NREQ) begin
                cand_s = cand_s - NREQ;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s[PTRW-1:0];
            end else begin
                found_s = found_s;
                win_s   = win_s;
            end
        end
    end

    // Winner's command fields and the pointer value that follows it.
    always_comb begin
        win_idx_s = idx[int'(win_s)*IDXW +: IDXW];
        win_op_s  = op[win_s];
        if (win_s == PTRW'(NREQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = win_s + PTRW'(1);
        end
    end

    // Arbiter FSM with pulse counter; every output is a flop written here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            win_r    <= '0;
            idx_r    <= '0;
            cnt_r    <= '0;
            gnt_r    <= '0;
            done_r   <= '0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            s_bus_r  <= '0;
            r_bus_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= '0;
                    err_r  <= 1'b0;
                    if (found_s) begin
                        state_r  <= DRIVE;
                        win_r    <= win_s;
                        idx_r    <= win_idx_s;
                        rr_ptr_r <= next_ptr_s;
                        cnt_r    <= CNTW'(PULSE_CYC - 1);
                        gnt_r    <= req_mask(win_s);
                        busy_r   <= 1'b1;
                        // Only one of the two buses is ever loaded.
                        s_bus_r  <= (win_op_s == OP_SET) ? cell_mask(win_idx_s) : '0;
                        r_bus_r  <= (win_op_s == OP_CLR) ? cell_mask(win_idx_s) : '0;
                    end else begin
                        gnt_r   <= '0;
                        busy_r  <= 1'b0;
                        s_bus_r <= '0;
                        r_bus_r <= '0;
                    end
                end
                DRIVE: begin
                    gnt_r <= '0;
                    if (cnt_r == '0) begin
                        state_r <= DONE;
                        s_bus_r <= '0;
                        r_bus_r <= '0;
                        done_r  <= req_mask(win_r);
                        err_r   <= (int'(idx_r) >= WIDTH);
                    end else begin
                        cnt_r <= cnt_r - CNTW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= '0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    s_bus_r <= '0;
                    r_bus_r <= '0;
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= '0;
                    done_r  <= '0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    s_bus_r <= '0;
                    r_bus_r <= '0;
                end
            endcase
        end
    end

    assign gnt   = gnt_r;
    assign done  = done_r;
    assign err   = err_r;
    assign busy  = busy_r;
    assign s_bus = s_bus_r;
    assign r_bus = r_bus_r;

    // The cells see the registered buses, so q follows one edge after gnt.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        sr_cell u_cell (
            .clk    (clk),
            .resetn (resetn),
            .s      (s_bus_r[g]),
            .r      (r_bus_r[g]),
            .q      (q[g]),
            .qb     (qb[g])
        );
    end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sr_bank_arbiter
// Bench for sr_bank_arbiter with NREQ=4, WIDTH=6 (so index 6/7 is out of
// range), PULSE_CYC=2. A timeline model (cycles since grant) predicts every
// output each cycle; directed sections add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_sr_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 6;
    localparam int PULSE = 2;
    localparam int IDXW  = 3;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      op;
    logic [NREQ*IDXW-1:0] idx;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic                 busy;
    logic [WIDTH-1:0]     s_bus;
    logic [WIDTH-1:0]     r_bus;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     qb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sr_bank_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .PULSE_CYC(PULSE), .IDXW(IDXW)
    ) dut (
        .clk(clk), .resetn(resetn), .req(req), .op(op), .idx(idx),
        .gnt(gnt), .done(done), .err(err), .busy(busy),
        .s_bus(s_bus), .r_bus(r_bus), .q(q), .qb(qb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- model: phase = cycles since grant, -1 when idle ----------
    int               m_phase;
    int               m_win;
    int               m_rr;
    int               m_idx;
    logic             m_op;
    logic [WIDTH-1:0] m_q;

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase <= -1;
            m_rr    <= 0;
            m_win   <= 0;
            m_idx   <= 0;
            m_op    <= 1'b0;
            m_q     <= '0;
        end else begin
            if (m_phase >= 0 && m_phase < PULSE && m_idx < WIDTH)
                m_q[m_idx] <= m_op;
            if (m_phase < 0) begin
                if (req != '0) begin
                    m_win   <= pick(req, m_rr);
                    m_op    <= op[pick(req, m_rr)];
                    m_idx   <= int'(idx[pick(req, m_rr)*IDXW +: IDXW]);
                    m_rr    <= (pick(req, m_rr) + 1) % NREQ;
                    m_phase <= 0;
                end
            end else if (m_phase == PULSE) begin
                m_phase <= -1;
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    logic [NREQ-1:0]  exp_gnt, exp_done;
    logic             exp_err, exp_busy;
    logic [WIDTH-1:0] exp_s, exp_r, exp_qb;

    always_comb begin
        exp_gnt  = '0;
        exp_done = '0;
        exp_err  = 1'b0;
        exp_s    = '0;
        exp_r    = '0;
        exp_busy = (m_phase >= 0);
        exp_qb   = ~m_q;
        if (m_phase == 0) exp_gnt[m_win] = 1'b1;
        if (m_phase >= 0 && m_phase < PULSE && m_idx < WIDTH) begin
            if (m_op) exp_s[m_idx] = 1'b1;
            else      exp_r[m_idx] = 1'b1;
        end
        if (m_phase == PULSE) begin
            exp_done[m_win] = 1'b1;
            exp_err         = (m_idx >= WIDTH);
        end
    end

    // Per-cycle compare against the model plus structural safety properties.
    always @(negedge clk) begin
        if (resetn) begin
            checkv("gnt",   gnt,   exp_gnt);
            checkv("done",  done,  exp_done);
            checkv("err",   err,   exp_err);
            checkv("busy",  busy,  exp_busy);
            checkv("s_bus", s_bus, exp_s);
            checkv("r_bus", r_bus, exp_r);
            checkv("q",     q,     m_q);
            checkv("qb",    qb,    exp_qb);
            checkv("s_and_r_zero", s_bus & r_bus, 0);
            checkv("bus_onehot0", ($countones(s_bus | r_bus) <= 1), 1);
            checkv("gnt_onehot0", ($countones(gnt) <= 1), 1);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_gnt(input logic [NREQ-1:0] m, input string nm);
        int n = 0;
        @(negedge clk);
        while (gnt !== m && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkv(nm, gnt, m);
    endtask

    task automatic wait_any_gnt(output int who, output int at);
        int n = 0;
        @(negedge clk);
        while (gnt == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        who = -1;
        for (int k = 0; k < NREQ; k++) if (gnt[k]) who = k;
        at = cyc;
        checkv("gnt_seen", (gnt != '0), 1);
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int who, at, prev_at, done_cnt;
        resetn = 1'b0;
        req = '0; op = '0; idx = '0;
        repeat (3) @(negedge clk);
        checkv("rst_q",    q,     6'h00);
        checkv("rst_qb",   qb,    6'h3F);
        checkv("rst_gnt",  gnt,   4'h0);
        checkv("rst_done", done,  4'h0);
        checkv("rst_busy", busy,  1'b0);
        checkv("rst_sbus", s_bus, 6'h00);
        resetn = 1'b1;

        // Reset in the middle of DRIVE: req[1] sets cell 3.
        req = 4'b0010; op = 4'b0010; idx = '0; idx[5:3] = 3'd3;
        wait_gnt(4'b0010, "mid_gnt");
        req = '0;
        @(negedge clk);
        checkv("mid_q_set", q, 6'h08);
        #2 resetn = 1'b0;
        #1;
        checkv("mid_rst_q",    q,     6'h00);
        checkv("mid_rst_qb",   qb,    6'h3F);
        checkv("mid_rst_gnt",  gnt,   4'h0);
        checkv("mid_rst_done", done,  4'h0);
        checkv("mid_rst_busy", busy,  1'b0);
        checkv("mid_rst_sbus", s_bus, 6'h00);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        done_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done != '0) done_cnt++;
        end
        checkv("mid_no_done", done_cnt, 0);

        // Single set of cell 5 by requester 0.
        req = 4'b0001; op = 4'b0001; idx = '0; idx[2:0] = 3'd5;
        wait_gnt(4'b0001, "set_gnt");
        req = '0;
        checkv("set_sbus0", s_bus, 6'h20);
        checkv("set_q0",    q,     6'h00);
        @(negedge clk);
        checkv("set_sbus1", s_bus, 6'h20);
        checkv("set_q1",    q,     6'h20);
        @(negedge clk);
        checkv("set_done",  done,  4'b0001);
        checkv("set_sbus2", s_bus, 6'h00);

        // Clear cell 5.
        req = 4'b0001; op = 4'b0000;
        wait_gnt(4'b0001, "clr_gnt");
        req = '0;
        checkv("clr_rbus0", r_bus, 6'h20);
        @(negedge clk);
        checkv("clr_q1",    q,     6'h00);
        @(negedge clk);
        checkv("clr_done",  done,  4'b0001);

        // Contention from a fresh reset: all four set their own index.
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        req = 4'b1111; op = 4'b1111;
        idx = {3'd3, 3'd2, 3'd1, 3'd0};
        prev_at = 0;
        for (int k = 0; k < 5; k++) begin
            wait_any_gnt(who, at);
            checkv($sformatf("cont_order%0d", k), who, exp_order[k]);
            if (k > 0) checkv($sformatf("cont_space%0d", k), at - prev_at, 4);
            prev_at = at;
        end
        checkv("cont_q", q, 6'h0F);
        req = '0;

        // Fairness: serve requester 1 (clear cell 1), then 3 and 0 together.
        req = 4'b0010; op = 4'b0000; idx[5:3] = 3'd1;
        wait_gnt(4'b0010, "rr_gnt1");
        req = 4'b1001; op = 4'b1001; idx[2:0] = 3'd2; idx[11:9] = 3'd4;
        wait_any_gnt(who, at);
        checkv("rr_first", who, 3);
        req[3] = 1'b0;
        wait_any_gnt(who, at);
        checkv("rr_second", who, 0);
        req[0] = 1'b0;
        repeat (6) @(negedge clk);
        checkv("rr_q", q, 6'h1D);

        // Out of range: requester 2 sets index 7 in a 6-cell bank.
        req = 4'b0100; op = 4'b0100; idx[8:6] = 3'd7;
        wait_gnt(4'b0100, "oor_gnt");
        req = '0;
        checkv("oor_bus0", s_bus | r_bus, 6'h00);
        @(negedge clk);
        checkv("oor_bus1", s_bus | r_bus, 6'h00);
        @(negedge clk);
        checkv("oor_done", done, 4'b0100);
        checkv("oor_err",  err,  1'b1);
        checkv("oor_q",    q,    6'h1D);

        // Random traffic; req held until granted, sometimes re-requested.
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req[i] = 1'b0;
                    end else begin
                        op[i] = 1'($urandom_range(0, 1));
                        idx[i*IDXW +: IDXW] = 3'($urandom_range(0, 7));
                    end
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    op[i] = 1'($urandom_range(0, 1));
                    idx[i*IDXW +: IDXW] = 3'($urandom_range(0, 7));
                end
            end
        end
        req = '0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_bank_arbiter.md
# sr_bank_arbiter

Controller that shares a bank of WIDTH edge-triggered SR storage cells between NREQ requesters. Each requester asks to set or clear one cell. The block grants requesters round-robin, one command at a time, and drives the cell's S or R line for a fixed pulse length. Because only one line is ever driven, the illegal S=R=1 input can never reach a cell. It sits between control agents (status/flag writers) and the flag bank whose q outputs feed the rest of the design.

## Interface
- NREQ, 4: number of requesters, 2..8
- WIDTH, 8: number of SR cells in the bank, 1..32
- PULSE_CYC, 2: cycles S/R is held active per command, 1..15
- IDXW, $clog2(WIDTH) (min 1): cell index width
- clk  input  1  rising-edge clock; single clock domain
- resetn  input  1  asynchronous, active-low reset
- req  input  NREQ  request per requester; level, held until gnt
- op  input  NREQ  per-requester operation: 1 = set, 0 = clear
- idx  input  NREQ*IDXW  per-requester cell index, packed, requester i at [i*IDXW +: IDXW]
- gnt  output  NREQ  one-hot, one-cycle grant pulse
- done  output  NREQ  one-hot, one-cycle completion pulse
- err  output  1  pulses with done when the granted idx >= WIDTH
- busy  output  1  high in any state other than IDLE
- s_bus  output  WIDTH  per-cell set lines, at most one bit high
- r_bus  output  WIDTH  per-cell clear lines, at most one bit high; never both s_bus[k] and r_bus[k]
- q  output  WIDTH  cell states
- qb  output  WIDTH  ~q

## Operation
- FSM states: IDLE, DRIVE, DONE.
- **IDLE**
  - If any req is high, pick the winner: the first requester at or after rr_ptr, searching upward with wrap.
  - Latch the winner's op and idx, pulse gnt[winner], go to DRIVE.
  - Set rr_ptr = winner+1 mod NREQ.
- **DRIVE**
  - If op=1 and idx<WIDTH: s_bus[idx]=1.
  - If op=0 and idx<WIDTH: r_bus[idx]=1.
  - If idx>=WIDTH: drive nothing.
  - Hold for exactly PULSE_CYC cycles (down-counter), then go to DONE.
- **DONE**
  - Pulse done[winner]. Pulse err if idx was out of range.
  - All buses are 0. Go to IDLE.
- **Cells**
  - On the clk edge, s=1 sets q=1 and r=1 sets q=0. Otherwise q holds.
  - Repeated set of a cell already at 1 leaves q=1 (idempotent).
- Requesters may drop req, or change op/idx, from the cycle after gnt. Values at the grant edge are the ones used.
- A requester that keeps req high after its done is re-arbitrated as a fresh request. Round-robin still applies.
- An unselected requester keeps waiting. No request is lost while its req is held.
- **Reset** (any time, including mid-DRIVE):
  - state=IDLE, rr_ptr=0, counter=0.
  - gnt=0, done=0, err=0, busy=0, s_bus=0, r_bus=0, q=0, qb=all ones.
  - An interrupted command is abandoned and no done is issued.

## Timing
- All outputs are registered; none are combinational from req.
- req high before edge E with the FSM in IDLE:
  - gnt visible after E.
  - s_bus/r_bus high from E to E+PULSE_CYC.
  - q changes after edge E+1.
  - done after edge E+PULSE_CYC.
  - IDLE again after E+PULSE_CYC+1.
- Command period: PULSE_CYC+2 cycles. Maximum wait for one requester: (NREQ-1)*(PULSE_CYC+2) cycles after its req is seen in IDLE.
- busy rises with gnt and falls with the edge ending DONE.
- req arriving during DRIVE/DONE is only considered in the next IDLE cycle.
- Simultaneous requests resolve purely by rr_ptr. op/idx of losers are ignored.

## Structure
- Package sr_bank_pkg holds:
  - the state enum {IDLE, DRIVE, DONE};
  - localparams OP_SET=1'b1 and OP_CLR=1'b0;
  - the counter width function.
- Sub-module sr_cell: one edge-triggered SR cell with async active-low reset, ports clk, resetn, s, r, q, qb. Instantiate it WIDTH times via generate.
- The arbiter, FSM and counter live in sr_bank_arbiter.

## Test plan
- Reset: hold resetn=0 for 3 cycles, then assert resetn=0 during DRIVE with req[1]=1, op=1, idx=3. Required: q=0x00, qb=0xFF, gnt=0, done=0, busy=0, s_bus=0, and no done[1].
- Single set/clear, PULSE_CYC=2:
  - req[0], op=1, idx=5: gnt[0] at E, s_bus=0x20 for 2 cycles, q=0x20, done[0] at E+2.
  - Then op=0, idx=5: r_bus=0x20, q=0x00.
- Contention: req=4'b1111 held, with each requester i targeting idx=i, op=1. Required grant order 0,1,2,3,0…, gnt spaced 4 cycles apart, q=0x0F after 4 dones.
- Round-robin fairness: rr_ptr=2 after serving requester 1, then req=4'b1001. Required: requester 3 is granted before requester 0.
- Out of range, WIDTH=6: idx=7, op=1. Required: s_bus=0, r_bus=0 throughout, done plus err in the same cycle, q unchanged.
- Safety check: random traffic for 10k cycles. Required: (s_bus & r_bus) == 0 always, popcount(s_bus|r_bus) <= 1, gnt one-hot, and every gnt followed by exactly one done PULSE_CYC cycles later.
